// File: rtl/port_arbiter6_pkg.sv
// rtl/port_arbiter6_pkg.sv - shared constants, state type and index helpers for port_arbiter6
package port_arbiter6_pkg;

  localparam int ARB_N = 6;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [ARB_N-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < ARB_N; i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

  // Rotate so that bit n lands at position 0.
  function automatic logic [ARB_N-1:0] rot_down(input logic [ARB_N-1:0] v,
                                                input logic [IDX_W-1:0] n);
    logic [2*ARB_N-1:0] dbl;
    dbl = {v, v} >> n;
    return dbl[ARB_N-1:0];
  endfunction

  function automatic logic [ARB_N-1:0] rot_up(input logic [ARB_N-1:0] v,
                                              input logic [IDX_W-1:0] n);
    logic [2*ARB_N-1:0] dbl;
    dbl = {v, v} << n;
    return dbl[2*ARB_N-1:ARB_N];
  endfunction

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(ARB_N - 1)) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/port_arbiter6_onehotmux.sv
// rtl/port_arbiter6_onehotmux.sv - six-input one-hot AND-OR data mux, input 0 when select is empty
module port_arbiter6_onehotmux
  import port_arbiter6_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [ARB_N-1:0] sel,
  input  logic [WIDTH-1:0] din [ARB_N],
  output logic [WIDTH-1:0] dout
);

  always_comb begin
    dout = '0;
    for (int i = 0; i < ARB_N; i++) begin
      dout = dout | (din[i] & {WIDTH{sel[i]}});
    end
    if (sel == '0) dout = din[0];
  end

endmodule

// File: rtl/port_arbiter6.sv
// rtl/port_arbiter6.sv - six-way round-robin burst arbiter for a shared valid/ready resource port
module port_arbiter6
  import port_arbiter6_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [ARB_N-1:0] req,
  input  logic [ARB_N-1:0] last,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
  input  logic [WIDTH-1:0] in5,
  input  logic             res_ready,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             res_last,
  output logic [ARB_N-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             busy
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  state_t           state, state_nx;
  logic [ARB_N-1:0] grant_nx;
  logic [IDX_W-1:0] idx_nx;
  logic [IDX_W-1:0] ptr, ptr_nx;
  logic [CNT_W-1:0] count, count_nx;
  logic [CNT_W-1:0] count_inc;

  logic [ARB_N-1:0] req_rot;
  logic [ARB_N-1:0] first_rot;
  logic [ARB_N-1:0] pick_oh;
  logic [IDX_W-1:0] pick_idx;
  logic             req_sel;
  logic             beat;

  logic [WIDTH-1:0] in_arr [ARB_N];

  assign in_arr[0] = in0;
  assign in_arr[1] = in1;
  assign in_arr[2] = in2;
  assign in_arr[3] = in3;
  assign in_arr[4] = in4;
  assign in_arr[5] = in5;

  // Priority pick: rotate ptr to bit 0, isolate lowest set bit, rotate back.
  assign req_rot   = rot_down(req, ptr);
  assign first_rot = req_rot & (~req_rot + 1'b1);
  assign pick_oh   = rot_up(first_rot, ptr);
  assign pick_idx  = onehot_to_idx(pick_oh);

  // The resource sees no beat during a reset cycle, even mid-burst.
  assign req_sel   = |(grant & req);
  assign res_valid = req_sel & reset_n;
  assign res_last  = |(grant & last);
  assign busy      = (state == GRANT);
  assign beat      = res_valid & res_ready;
  assign count_inc = count + 1'b1;

  port_arbiter6_onehotmux #(
    .WIDTH(WIDTH)
  ) u_mux (
    .sel (grant),
    .din (in_arr),
    .dout(res_data)
  );

  always_comb begin
    state_nx = state;
    grant_nx = grant;
    idx_nx   = grant_idx;
    ptr_nx   = ptr;
    count_nx = count;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nx = GRANT;
          grant_nx = pick_oh;
          idx_nx   = pick_idx;
          count_nx = '0;
        end
      end
      GRANT: begin
        if (!req_sel) begin
          state_nx = IDLE;
          grant_nx = '0;
          idx_nx   = '0;
          ptr_nx   = next_idx(grant_idx);
          count_nx = '0;
        end else if (beat) begin
          count_nx = count_inc;
          if (res_last || (count_inc == CNT_MAX)) begin
            state_nx = IDLE;
            grant_nx = '0;
            idx_nx   = '0;
            ptr_nx   = next_idx(grant_idx);
            count_nx = '0;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        grant_nx = '0;
        idx_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      grant     <= '0;
      grant_idx <= '0;
      ptr       <= '0;
      count     <= '0;
    end else begin
      state     <= state_nx;
      grant     <= grant_nx;
      grant_idx <= idx_nx;
      ptr       <= ptr_nx;
      count     <= count_nx;
    end
  end

endmodule
